// File: rtl/tank_pkg.sv
// Shared tank-game constants: grid limits, parking coordinate and the
// direction encoding, plus the field-edge test used by each bullet slot.
package tank_pkg;

    localparam int CW = 5;

    localparam logic [1:0] DIR_UP = 2'b00;
    localparam logic [1:0] DIR_DN = 2'b01;
    localparam logic [1:0] DIR_LF = 2'b10;
    localparam logic [1:0] DIR_RT = 2'b11;

    localparam logic [CW-1:0] X_MAX = 5'd15;
    localparam logic [CW-1:0] Y_MAX = 5'd19;
    localparam logic [CW-1:0] PARK  = 5'd31;

    // True when one more step in dir would leave the field.
    function automatic logic at_edge(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic [1:0]    dir
    );
        logic e;
        e = 1'b0;
        unique case (dir)
            DIR_UP: e = (y == Y_MAX);
            DIR_DN: e = (y == '0);
            DIR_LF: e = (x == X_MAX);
            DIR_RT: e = (x == '0);
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet: active flag, position and heading. Loads on spawn, steps on
// tick, retires at the field edge, clears on a target match.
// Ports: clk/rst; load + ld_x/ld_y/ld_dir spawn data; step move tick;
// tgt_valid/tgt_x/tgt_y target; act/x/y registered state (PARK when idle);
// match = this slot sits on the target; act_nxt = next-cycle active flag.
module bullet_slot
    import tank_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] ld_x,
    input  logic [CW-1:0] ld_y,
    input  logic [1:0]    ld_dir,
    input  logic          step,
    input  logic          tgt_valid,
    input  logic [CW-1:0] tgt_x,
    input  logic [CW-1:0] tgt_y,
    output logic          act,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          match,
    output logic          act_nxt
);

    logic [1:0]    dir;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic [1:0]    dir_nxt;

    assign match = act & tgt_valid & (x == tgt_x) & (y == tgt_y);

    // Priority: spawn (only ever into an idle slot) > hit > edge > move.
    always_comb begin
        act_nxt = act;
        x_nxt   = x;
        y_nxt   = y;
        dir_nxt = dir;
        if (load) begin
            act_nxt = 1'b1;
            x_nxt   = ld_x;
            y_nxt   = ld_y;
            dir_nxt = ld_dir;
        end else if (act) begin
            if (match) begin
                act_nxt = 1'b0;
                x_nxt   = PARK;
                y_nxt   = PARK;
            end else if (step) begin
                if (at_edge(x, y, dir)) begin
                    act_nxt = 1'b0;
                    x_nxt   = PARK;
                    y_nxt   = PARK;
                end else begin
                    unique case (dir)
                        DIR_UP: y_nxt = y + 5'd1;
                        DIR_DN: y_nxt = y - 5'd1;
                        DIR_LF: x_nxt = x + 5'd1;
                        DIR_RT: x_nxt = x - 5'd1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act <= 1'b0;
            x   <= PARK;
            y   <= PARK;
            dir <= DIR_UP;
        end else begin
            act <= act_nxt;
            x   <= x_nxt;
            y   <= y_nxt;
            dir <= dir_nxt;
        end
    end

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet controller: tick synchroniser, fire edge detect, spawn
// cooldown, lowest-free-slot allocation, hit pulse and active count.
// Ports: clk/rst; clk_4Hz game tick level; tank_en/bul_sht/tank_x/tank_y/
// tank_dir from the tank; tgt_valid/tgt_x/tgt_y target; bul_x/bul_y packed
// slot positions; bul_act slot flags; bul_cnt active count; hit pulse.
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int NUM_BUL  = 4,
    parameter int COOLDOWN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_4Hz,
    input  logic                    tank_en,
    input  logic                    bul_sht,
    input  logic [CW-1:0]           tank_x,
    input  logic [CW-1:0]           tank_y,
    input  logic [1:0]              tank_dir,
    input  logic                    tgt_valid,
    input  logic [CW-1:0]           tgt_x,
    input  logic [CW-1:0]           tgt_y,
    output logic [CW*NUM_BUL-1:0]   bul_x,
    output logic [CW*NUM_BUL-1:0]   bul_y,
    output logic [NUM_BUL-1:0]      bul_act,
    output logic [2:0]              bul_cnt,
    output logic                    hit
);

    localparam int CDW = $clog2(COOLDOWN + 1);

    logic               s1, s2, s3;
    logic               tick;
    logic               sht_q;
    logic               fire;
    logic [CDW-1:0]     cd;
    logic [NUM_BUL-1:0] free;
    logic [NUM_BUL-1:0] sel;
    logic               spawn;
    logic [NUM_BUL-1:0] load;
    logic [NUM_BUL-1:0] match;
    logic [NUM_BUL-1:0] act_nxt;
    logic [2:0]         cnt_nxt;

    assign fire  = bul_sht & ~sht_q;
    assign free  = ~bul_act;
    // Isolate the lowest set bit of free.
    assign sel   = free & (~free + 1'b1);
    assign spawn = fire & tank_en & (cd == '0) & (|free);
    assign load  = spawn ? sel : '0;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_BUL; i++) begin
            cnt_nxt = cnt_nxt + 3'(act_nxt[i]);
        end
    end

    for (genvar g = 0; g < NUM_BUL; g++) begin : g_slot
        bullet_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .ld_x      (tank_x),
            .ld_y      (tank_y),
            .ld_dir    (tank_dir),
            .step      (tick),
            .tgt_valid (tgt_valid),
            .tgt_x     (tgt_x),
            .tgt_y     (tgt_y),
            .act       (bul_act[g]),
            .x         (bul_x[CW*g +: CW]),
            .y         (bul_y[CW*g +: CW]),
            .match     (match[g]),
            .act_nxt   (act_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            tick    <= 1'b0;
            sht_q   <= 1'b0;
            cd      <= '0;
            bul_cnt <= '0;
            hit     <= 1'b0;
        end else begin
            s1      <= clk_4Hz;
            s2      <= s1;
            s3      <= s2;
            tick    <= s2 & ~s3;
            sht_q   <= bul_sht;
            bul_cnt <= cnt_nxt;
            hit     <= |match;
            if (spawn) begin
                cd <= CDW'(COOLDOWN);
            end else if (tick && cd != '0) begin
                cd <= cd - CDW'(1);
            end
        end
    end

endmodule
